// File: rtl/lift_req_queue_if.sv
// rtl/lift_req_queue_if.sv - hall-call queue port bundle: button input, LiftFSM head/pop, lamp and reject status
interface lift_req_queue_if #(
  parameter int AW = 3
);
  logic          btn_valid;
  logic [2:0]    btn_code;
  logic          done;
  logic [2:0]    din;
  logic          qEmpty;
  logic          full;
  logic [AW:0]   count;
  logic [7:0]    pending;
  logic          rej;
  logic [1:0]    rej_why;

  modport master (
    output btn_valid, btn_code, done,
    input  din, qEmpty, full, count, pending, rej, rej_why
  );

  modport slave (
    input  btn_valid, btn_code, done,
    output din, qEmpty, full, count, pending, rej, rej_why
  );
endinterface

// File: rtl/lift_req_queue.sv
// rtl/lift_req_queue.sv - FIFO of hall-call codes with invalid/duplicate/full rejection and call-lamp bitmap
module lift_req_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  lift_req_queue_if.slave     q
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_pending;
  logic          r_rej;
  logic [1:0]    r_rej_why;

  logic [2:0]    w_head;
  logic          w_pop;
  logic          w_full;
  logic          w_bad;
  logic          w_dup;
  logic [7:0]    w_pend_eff;
  logic [1:0]    w_why;
  logic          w_push;

  // A same-edge pop frees both the head's lamp and a slot before the press is judged.
  always_comb begin
    w_head     = r_mem[r_rd_ptr];
    w_pop      = q.done && (r_count != '0);
    w_full     = (r_count == LP_DEPTH);
    w_pend_eff = r_pending;
    if (w_pop) begin
      w_pend_eff[w_head] = 1'b0;
    end
    w_bad = (q.btn_code == 3'b000) || (q.btn_code == 3'b101);
    w_dup = w_pend_eff[q.btn_code];
    w_why = 2'b00;
    if (q.btn_valid) begin
      if (w_bad) begin
        w_why = 2'b01;
      end else if (w_dup) begin
        w_why = 2'b10;
      end else if (w_full && !w_pop) begin
        w_why = 2'b11;
      end
    end
    w_push = q.btn_valid && (w_why == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= q.btn_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= 8'h00;
      r_rej     <= 1'b0;
      r_rej_why <= 2'b00;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_pending <= w_pend_eff | (w_push ? (8'b1 << q.btn_code) : 8'b0);
      r_rej     <= (w_why != 2'b00);
      r_rej_why <= w_why;
    end
  end

  assign q.din     = (r_count != '0) ? w_head : 3'b000;
  assign q.qEmpty  = (r_count == '0);
  assign q.full    = w_full;
  assign q.count   = r_count;
  assign q.pending = r_pending;
  assign q.rej     = r_rej;
  assign q.rej_why = r_rej_why;

endmodule

// File: tb/tb_lift_req_queue.sv
// tb/tb_lift_req_queue.sv - scoreboard bench driving DEPTH=4 and DEPTH=8 queues with identical stimulus
module tb_lift_req_queue;

  logic clk;
  logic rst_n;

  lift_req_queue_if #(.AW(2)) if4 ();
  lift_req_queue_if #(.AW(3)) if8 ();

  lift_req_queue #(.DEPTH(4), .AW(2)) u_dut4 (.clk(clk), .rst_n(rst_n), .q(if4.slave));
  lift_req_queue #(.DEPTH(8), .AW(3)) u_dut8 (.clk(clk), .rst_n(rst_n), .q(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] din;
    logic       qe;
    logic       full;
    logic [3:0] cnt;
    logic [7:0] pend;
    logic       rej;
    logic [1:0] why;
  } exp_t;

  exp_t       sb4[$];
  exp_t       sb8[$];
  logic [2:0] m_ent [2][8];
  int         m_cnt [2];
  int         m_depth [2];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pend_of(input int s);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < m_cnt[s]; i++) p[m_ent[s][i]] = 1'b1;
    return p;
  endfunction

  // Reference: shift-array FIFO, rejection judged after a same-edge pop frees the head.
  task automatic model(input int s, input logic v, input logic [2:0] c, input logic d, input logic rn);
    logic [7:0] pe;
    logic       pop;
    logic [1:0] why = 2'b00;
    exp_t       e;
    if (!rn) begin
      m_cnt[s] = 0;
    end else begin
      pop = d && (m_cnt[s] > 0);
      pe  = pend_of(s);
      if (pop) pe[m_ent[s][0]] = 1'b0;
      if (v) begin
        if (c == 3'd0 || c == 3'd5)                   why = 2'b01;
        else if (pe[c])                               why = 2'b10;
        else if (m_cnt[s] == m_depth[s] && !pop)      why = 2'b11;
      end
      if (pop) begin
        for (int i = 0; i < 7; i++) m_ent[s][i] = m_ent[s][i+1];
        m_cnt[s]--;
      end
      if (v && why == 2'b00) begin
        m_ent[s][m_cnt[s]] = c;
        m_cnt[s]++;
      end
    end
    e.din  = (m_cnt[s] > 0) ? m_ent[s][0] : 3'b000;
    e.qe   = (m_cnt[s] == 0);
    e.full = (m_cnt[s] == m_depth[s]);
    e.cnt  = 4'(m_cnt[s]);
    e.pend = pend_of(s);
    e.rej  = (why != 2'b00);
    e.why  = why;
    if (s == 0) sb4.push_back(e);
    else        sb8.push_back(e);
  endtask

  task automatic compare(input string nm, input exp_t g, input exp_t e);
    check({nm, ".din"},     32'(g.din),  32'(e.din));
    check({nm, ".qEmpty"},  32'(g.qe),   32'(e.qe));
    check({nm, ".full"},    32'(g.full), 32'(e.full));
    check({nm, ".count"},   32'(g.cnt),  32'(e.cnt));
    check({nm, ".pending"}, 32'(g.pend), 32'(e.pend));
    check({nm, ".rej"},     32'(g.rej),  32'(e.rej));
    check({nm, ".rej_why"}, 32'(g.why),  32'(e.why));
  endtask

  task automatic cyc(input logic v, input logic [2:0] c, input logic d, input logic rn);
    exp_t g;
    @(negedge clk);
    rst_n = rn;
    if4.btn_valid = v; if4.btn_code = c; if4.done = d;
    if8.btn_valid = v; if8.btn_code = c; if8.done = d;
    model(0, v, c, d, rn);
    model(1, v, c, d, rn);
    @(posedge clk);
    #1;
    if (sb4.size() == 0 || sb8.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      g = '{if4.din, if4.qEmpty, if4.full, 4'(if4.count), if4.pending, if4.rej, if4.rej_why};
      compare("d4", g, sb4.pop_front());
      g = '{if8.din, if8.qEmpty, if8.full, if8.count, if8.pending, if8.rej, if8.rej_why};
      compare("d8", g, sb8.pop_front());
    end
  endtask

  task automatic push(input logic [2:0] c);
    cyc(1'b1, c, 1'b0, 1'b1);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'b000, 1'b1, 1'b1);
  endtask

  initial begin
    m_depth[0] = 4;
    m_depth[1] = 8;
    m_cnt[0]   = 0;
    m_cnt[1]   = 0;
    rst_n = 1'b0;
    if4.btn_valid = 1'b0; if4.btn_code = 3'b000; if4.done = 1'b0;
    if8.btn_valid = 1'b0; if8.btn_code = 3'b000; if8.done = 1'b0;

    cyc(1'b0, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 1'b0);
    check("rst_qEmpty", 32'(if8.qEmpty), 32'd1);

    push(3'b001);
    check("t1_din", 32'(if8.din), 32'd1);
    check("t1_pending", 32'(if8.pending), 32'h02);
    pop_n(1);

    push(3'b011); push(3'b110); push(3'b100);
    pop_n(1);
    check("t2_din1", 32'(if8.din), 32'b110);
    pop_n(2);
    check("t2_empty", 32'(if8.qEmpty), 32'd1);
    check("t2_pending", 32'(if8.pending), 32'h00);

    push(3'b010);
    push(3'b010);
    check("t3_dup", 32'(if8.rej_why), 32'b10);
    push(3'b101);
    check("t3_inv5", 32'(if8.rej_why), 32'b01);
    push(3'b000);
    check("t3_inv0", 32'(if8.rej_why), 32'b01);
    check("t3_count", 32'(if8.count), 32'd1);
    pop_n(1);

    push(3'b001); push(3'b010); push(3'b011); push(3'b110);
    check("t4_full", 32'(if4.full), 32'd1);
    push(3'b111);
    check("t4_rejfull", 32'(if4.rej_why), 32'b11);
    cyc(1'b1, 3'b111, 1'b1, 1'b1);
    check("t4_pp_rej", 32'(if4.rej), 32'd0);
    check("t4_pp_count", 32'(if4.count), 32'd4);
    check("t4_pp_din", 32'(if4.din), 32'b010);
    pop_n(6);

    push(3'b011);
    cyc(1'b1, 3'b011, 1'b1, 1'b1);
    check("t5_count", 32'(if8.count), 32'd1);
    check("t5_pend3", 32'(if8.pending[3]), 32'd1);
    check("t5_rej", 32'(if8.rej), 32'd0);
    pop_n(1);

    push(3'b001); push(3'b010); push(3'b011);
    cyc(1'b1, 3'b100, 1'b1, 1'b0);
    check("t6_count", 32'(if8.count), 32'd0);
    check("t6_pending", 32'(if8.pending), 32'h00);
    pop_n(2);
    check("t6_din", 32'(if8.din), 32'd0);

    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) != 0));
    end
    pop_n(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
